// File: rtl/isq_sel.sv
// Issue-queue select: per-port pick of one ready entry, ports resolved in order 0..NUM_PORT-1.
// Define ISQ_SEL_RR_EN for per-port round-robin priority; default is fixed priority (entry 0 highest).
module isq_sel #(
  parameter int ISQ_DEPTH = 64,
  parameter int IDX_W     = 6,
  parameter int PKT_W     = 66,
  parameter int NUM_PORT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [ISQ_DEPTH-1:0]          req_vld,
  input  logic [ISQ_DEPTH*NUM_PORT-1:0] req_cap_flat,
  input  logic [ISQ_DEPTH*PKT_W-1:0]    req_pkt_flat,
  input  logic [NUM_PORT-1:0]           iss_rdy,
  output logic [NUM_PORT-1:0]           iss_vld,
  output logic [NUM_PORT*PKT_W-1:0]     iss_pkt_flat,
  output logic [NUM_PORT*IDX_W-1:0]     iss_idx_flat,
  output logic [ISQ_DEPTH-1:0]          clr_inst_wat
);

  logic [NUM_PORT-1:0]  open_s;
  logic [NUM_PORT-1:0]  sel_vld_s;
  logic [IDX_W-1:0]     sel_idx_s [NUM_PORT];
  logic [ISQ_DEPTH-1:0] taken_s;
`ifdef ISQ_SEL_RR_EN
  logic [IDX_W-1:0]     ptr_r [NUM_PORT];
`endif

  // Per-port selection; taken_s accumulates picks so later ports skip them.
  always_comb begin
    int  base;
    int  k;
    logic hit;
    open_s    = '0;
    sel_vld_s = '0;
    taken_s   = '0;
    base      = 0;
    k         = 0;
    hit       = 1'b0;
    for (int p = 0; p < NUM_PORT; p++) begin
      sel_idx_s[p] = '0;
      open_s[p]    = ~iss_vld[p] | iss_rdy[p];
`ifdef ISQ_SEL_RR_EN
      base = int'(ptr_r[p]);
`else
      base = 0;
`endif
      if (open_s[p] && !flush) begin
        for (int j = 0; j < ISQ_DEPTH; j++) begin
          k   = base + j;
          k   = (k >= ISQ_DEPTH) ? (k - ISQ_DEPTH) : k;
          hit = ~sel_vld_s[p] & req_vld[k] & req_cap_flat[k*NUM_PORT + p]
              & ~clr_inst_wat[k] & ~taken_s[k];
          sel_idx_s[p] = hit ? IDX_W'(k) : sel_idx_s[p];
          sel_vld_s[p] = sel_vld_s[p] | hit;
        end
        taken_s[sel_idx_s[p]] = taken_s[sel_idx_s[p]] | sel_vld_s[p];
      end else begin
        sel_vld_s[p] = 1'b0;
      end
    end
  end

  // Output registers, wait-clear pulse and priority pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld      <= '0;
      iss_pkt_flat <= '0;
      iss_idx_flat <= '0;
      clr_inst_wat <= '0;
`ifdef ISQ_SEL_RR_EN
      for (int p = 0; p < NUM_PORT; p++) begin
        ptr_r[p] <= '0;
      end
`endif
    end else begin
      clr_inst_wat <= taken_s;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (flush) begin
          iss_vld[p] <= 1'b0;
        end else if (open_s[p]) begin
          iss_vld[p] <= sel_vld_s[p];
          if (sel_vld_s[p]) begin
            iss_pkt_flat[p*PKT_W +: PKT_W] <= req_pkt_flat[int'(sel_idx_s[p])*PKT_W +: PKT_W];
            iss_idx_flat[p*IDX_W +: IDX_W] <= sel_idx_s[p];
          end
        end
`ifdef ISQ_SEL_RR_EN
        // sel_vld_s is already suppressed during flush, so pointers hold then.
        if (sel_vld_s[p]) begin
          ptr_r[p] <= (sel_idx_s[p] == IDX_W'(ISQ_DEPTH - 1)) ? '0 : sel_idx_s[p] + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_isq_sel.sv
// Directed bench for isq_sel with default parameters; expected picks are hand-derived.
module tb_isq_sel;

  localparam int DEPTH = 64;
  localparam int IW    = 6;
  localparam int PW    = 66;
  localparam int NP    = 4;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic [DEPTH-1:0]     req_vld;
  logic [DEPTH*NP-1:0]  req_cap_flat;
  logic [DEPTH*PW-1:0]  req_pkt_flat;
  logic [NP-1:0]        iss_rdy;
  logic [NP-1:0]        iss_vld;
  logic [NP*PW-1:0]     iss_pkt_flat;
  logic [NP*IW-1:0]     iss_idx_flat;
  logic [DEPTH-1:0]     clr_inst_wat;

  int checks   = 0;
  int failures = 0;

  isq_sel #(.ISQ_DEPTH(DEPTH), .IDX_W(IW), .PKT_W(PW), .NUM_PORT(NP)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_vld      (req_vld),
    .req_cap_flat (req_cap_flat),
    .req_pkt_flat (req_pkt_flat),
    .iss_rdy      (iss_rdy),
    .iss_vld      (iss_vld),
    .iss_pkt_flat (iss_pkt_flat),
    .iss_idx_flat (iss_idx_flat),
    .clr_inst_wat (clr_inst_wat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pkt_of(int i);
    return {2'(i), 32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1)};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [NP-1:0] cap);
    req_vld[i] = 1'b1;
    req_cap_flat[i*NP +: NP] = cap;
  endtask

  task automatic clr_req();
    req_vld      = '0;
    req_cap_flat = '0;
  endtask

  function automatic logic [IW-1:0] idx_on(int p);
    return iss_idx_flat[p*IW +: IW];
  endfunction

  function automatic logic [PW-1:0] pkt_on(int p);
    return iss_pkt_flat[p*PW +: PW];
  endfunction

  int rr_seq [6];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    iss_rdy = 4'hF;
    clr_req();
    for (int i = 0; i < DEPTH; i++) req_pkt_flat[i*PW +: PW] = pkt_of(i);

    // reset state, then an idle cycle
    tick();
    check("rst_vld", iss_vld, 4'h0);
    check("rst_pkt", iss_pkt_flat, '0);
    check("rst_idx", iss_idx_flat, '0);
    check("rst_clr", clr_inst_wat, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_vld", iss_vld, 4'h0);
    check("idle_clr", clr_inst_wat, 64'd0);

    // entries 5 and 9 on port 0; in-flight mask keeps 5 out on the second pick
    set_req(5, 4'b0001);
    set_req(9, 4'b0001);
    tick();
    check("s1_vld_a", iss_vld, 4'b0001);
    check("s1_idx_a", idx_on(0), 6'd5);
    check("s1_pkt_a", pkt_on(0), pkt_of(5));
    check("s1_clr_a", clr_inst_wat, 64'd1 << 5);
    tick();
    check("s1_vld_b", iss_vld, 4'b0001);
    check("s1_idx_b", idx_on(0), 6'd9);
    check("s1_pkt_b", pkt_on(0), pkt_of(9));
    check("s1_clr_b", clr_inst_wat, 64'd1 << 9);
    clr_req();
    tick();
    check("s1_vld_c", iss_vld, 4'b0000);
    check("s1_clr_c", clr_inst_wat, 64'd0);

    // entry 3 capable on ports 0 and 1: only port 0 takes it
    set_req(3, 4'b0011);
    tick();
    check("s2_vld", iss_vld, 4'b0001);
    check("s2_idx", idx_on(0), 6'd3);
    check("s2_clr", clr_inst_wat, 64'd1 << 3);
    clr_req();

    // port 2 stalls holding entry 7; entry 8 waits for the stall to end
    iss_rdy = 4'b1011;
    set_req(7, 4'b0100);
    tick();
    check("s3_vld_a", iss_vld, 4'b0100);
    check("s3_idx_a", idx_on(2), 6'd7);
    check("s3_clr_a", clr_inst_wat, 64'd1 << 7);
    clr_req();
    set_req(8, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("s3_hold_vld", iss_vld, 4'b0100);
      check("s3_hold_idx", idx_on(2), 6'd7);
      check("s3_hold_pkt", pkt_on(2), pkt_of(7));
      check("s3_hold_clr", clr_inst_wat, 64'd0);
    end
    iss_rdy = 4'hF;
    tick();
    check("s3_vld_b", iss_vld, 4'b0100);
    check("s3_idx_b", idx_on(2), 6'd8);
    check("s3_pkt_b", pkt_on(2), pkt_of(8));
    check("s3_clr_b", clr_inst_wat, 64'd1 << 8);
    clr_req();
    tick();
    check("s3_vld_c", iss_vld, 4'b0000);

    // all four ports busy, then flush, then rst+flush with ports stalled
    set_req(10, 4'b0001);
    set_req(11, 4'b0010);
    set_req(12, 4'b0100);
    set_req(13, 4'b1000);
    tick();
    check("s4_vld_a", iss_vld, 4'hF);
    check("s4_clr_a", clr_inst_wat, 64'h3C00);
    check("s4_idx3_a", idx_on(3), 6'd13);
    flush = 1'b1;
    tick();
    check("s4_fl_vld", iss_vld, 4'h0);
    check("s4_fl_clr", clr_inst_wat, 64'd0);
    check("s4_fl_idx0", idx_on(0), 6'd10);
    flush = 1'b0;
    tick();
    check("s4_vld_b", iss_vld, 4'hF);
    check("s4_clr_b", clr_inst_wat, 64'h3C00);
    iss_rdy = 4'h0;
    rst = 1'b1;
    flush = 1'b1;
    tick();
    check("s4_rst_vld", iss_vld, 4'h0);
    check("s4_rst_pkt", iss_pkt_flat, '0);
    check("s4_rst_idx", iss_idx_flat, '0);
    check("s4_rst_clr", clr_inst_wat, 64'd0);
    rst = 1'b0;
    flush = 1'b0;
    iss_rdy = 4'hF;
    clr_req();
    tick();
    check("s4_post_vld", iss_vld, 4'h0);
    check("s4_post_clr", clr_inst_wat, 64'd0);

    // entries 0, 1, 63 always ready on port 3
`ifdef ISQ_SEL_RR_EN
    rr_seq = '{0, 1, 63, 0, 1, 63};
`else
    rr_seq = '{0, 1, 0, 1, 0, 1};
`endif
    set_req(0, 4'b1000);
    set_req(1, 4'b1000);
    set_req(63, 4'b1000);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("s5_vld", iss_vld, 4'b1000);
      check("s5_idx", idx_on(3), 6'(rr_seq[c]));
      check("s5_clr", clr_inst_wat, 64'd1 << rr_seq[c]);
    end
    clr_req();
    tick();
    check("s5_end_vld", iss_vld, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
